stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
Downstream consumer of the 10 Hz divided clock in the stopwatch design. Counts 0.1 s ticks into BCD digits MM:SS.t, with start/stop, clear and lap-freeze controls. Outputs feed the seven-segment display decoders.

Parameters:
MIN_LIMIT, 60, minute count at which the time wraps to 00:00.0 (legal range 1..60)

Ports:
iclk  input  1  system clock, same clock that drives the 10 Hz divider
irst_n  input  1  asynchronous active-low reset
itick_10hz  input  1  10 Hz square wave from the divider, synchronous to iclk
istart_stop  input  1  start/stop control, debounced, synchronous level; action on rising edge
iclear  input  1  clear control, debounced, synchronous level; action on rising edge
ilap  input  1  lap control, debounced, synchronous level; action on rising edge
otenths  output  4  BCD tenths of a second, 0-9
osec_ones  output  4  BCD seconds units, 0-9
osec_tens  output  3  seconds tens, 0-5
omin_ones  output  4  BCD minutes units, 0-9
omin_tens  output  3  minutes tens, 0-5
orunning  output  1  high in RUN
ofrozen  output  1  high while the display shows the lap snapshot
ooverflow  output  1  sticky, set on wrap past the last minute

Behaviour:
- All state is reset asynchronously on irst_n low.
- Reset values: all digits 0, snapshot 0, orunning 0, ofrozen 0, ooverflow 0, FSM IDLE.
- Reset values of the edge-detect history registers: itick history 1, so no tick is counted out of reset while the input is high. Button histories 0.
- tick = itick_10hz sampled 1 while its history is 0. This is a single-cycle event per rising edge of itick_10hz.
- Button events are defined the same way, from rising edges. Holding a button produces exactly one event.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: start event -> RUN. Clear event is a no-op.
  - RUN: start event -> PAUSE. Clear event is ignored.
  - PAUSE: start event -> RUN. Clear event -> IDLE, zeroing digits and ooverflow and dropping the freeze.
- Counting: a tick increments the live counter only when the current (pre-edge) state is RUN.
  - A tick in the same cycle as a stop event is counted.
  - A tick in the same cycle as a start event from IDLE or PAUSE is not counted.
- Latency: live digits change on the same iclk edge at which the tick is detected.
- Carry chain:
  - tenths 9 -> 0 carries into sec_ones.
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into min_ones.
  - min_ones 9 -> 0 carries into min_tens.
- Wrap: a tick at minutes = MIN_LIMIT-1, 59.9 s sets all digits to 0 and sets ooverflow. ooverflow stays set until clear from PAUSE or reset.
- Minutes are held as a BCD pair. Digits never take values outside their legal range.
- Lap behaviour:
  - A lap event in RUN or PAUSE while ofrozen=0 captures the live digits into the snapshot and sets ofrozen. The captured value is the pre-update value if a tick occurs in the same cycle.
  - A lap event while ofrozen=1 clears ofrozen.
  - A lap event in IDLE is ignored.
  - Live counting continues while frozen.
- Display outputs are the snapshot when ofrozen=1, otherwise the live digits. Selection is combinational from registers; there is no extra cycle of latency.
- Simultaneous events in one cycle: clear is evaluated first, then start, then lap.
  - Clear and start together in PAUSE -> IDLE, start ignored.
  - Clear and lap together in PAUSE -> IDLE, unfrozen.
- Reset asserted mid-count forces the reset values immediately and asynchronously. After release, counting resumes only after a new start event.

Test Plan:
- Reset then 5 itick_10hz edges with no start -> digits stay 00:00.0, orunning=0.
- Start, then 25 tick edges, then stop -> digits 00:02.5, orunning=0. A further 3 ticks leave 00:02.5. Start plus 1 tick gives 00:02.6.
- Preload by running 35999 ticks with MIN_LIMIT=60 -> 59:59.9. One more tick -> 00:00.0 with ooverflow=1. Stop then clear -> ooverflow=0, IDLE.
- Run to 00:01.3, lap -> display frozen at 00:01.3, ofrozen=1. 7 ticks later display still shows 00:01.3. Lap again -> display shows 00:02.0.
- In PAUSE, assert istart_stop and iclear in the same cycle -> IDLE, digits 0, orunning=0. In RUN, clear alone -> ignored, count unchanged.
- Pulse irst_n low mid-run at 00:04.7 -> all outputs 0 immediately. After release, ticks without start do not count. Holding istart_stop high for 20 cycles gives exactly one start.

Source files
------------

// File: rtl/stopwatch_core.sv
// BCD stopwatch MM:SS.t counting 10 Hz tick edges, with start/stop, clear and lap freeze.
// Latency: live digits update on the iclk edge that detects the tick; display mux is combinational.
// No backpressure: every tick and button rising edge is consumed in the cycle it is detected.
module stopwatch_core #(
    parameter int MIN_LIMIT = 60
) (
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       itick_10hz,
    input  logic       istart_stop,
    input  logic       iclear,
    input  logic       ilap,
    output logic [3:0] otenths,
    output logic [3:0] osec_ones,
    output logic [2:0] osec_tens,
    output logic [3:0] omin_ones,
    output logic [2:0] omin_tens,
    output logic       orunning,
    output logic       ofrozen,
    output logic       ooverflow
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [2:0] LAST_MIN_TENS = 3'((MIN_LIMIT - 1) / 10);
    localparam logic [3:0] LAST_MIN_ONES = 4'((MIN_LIMIT - 1) % 10);

    state_t     state;
    logic       tick_q, ss_q, clr_q, lap_q;
    logic [3:0] tenths, sec_ones, min_ones;
    logic [2:0] sec_tens, min_tens;
    logic [3:0] snap_tenths, snap_sec_ones, snap_min_ones;
    logic [2:0] snap_sec_tens, snap_min_tens;

    logic tick_ev, ss_ev, clr_ev, lap_ev, at_last_min;

    assign tick_ev     = itick_10hz & ~tick_q;
    assign ss_ev       = istart_stop & ~ss_q;
    assign clr_ev      = iclear & ~clr_q;
    assign lap_ev      = ilap & ~lap_q;
    assign at_last_min = (min_tens == LAST_MIN_TENS) && (min_ones == LAST_MIN_ONES);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state         <= IDLE;
            tick_q        <= 1'b1;
            ss_q          <= 1'b0;
            clr_q         <= 1'b0;
            lap_q         <= 1'b0;
            tenths        <= '0;
            sec_ones      <= '0;
            sec_tens      <= '0;
            min_ones      <= '0;
            min_tens      <= '0;
            snap_tenths   <= '0;
            snap_sec_ones <= '0;
            snap_sec_tens <= '0;
            snap_min_ones <= '0;
            snap_min_tens <= '0;
            orunning      <= 1'b0;
            ofrozen       <= 1'b0;
            ooverflow     <= 1'b0;
        end else begin
            tick_q <= itick_10hz;
            ss_q   <= istart_stop;
            clr_q  <= iclear;
            lap_q  <= ilap;

            // Counting keys off the pre-edge state, so a tick alongside a stop still counts.
            if (state == RUN && tick_ev) begin
                if (tenths == 4'd9) begin
                    tenths <= '0;
                    if (sec_ones == 4'd9) begin
                        sec_ones <= '0;
                        if (sec_tens == 3'd5) begin
                            sec_tens <= '0;
                            if (at_last_min) begin
                                min_ones  <= '0;
                                min_tens  <= '0;
                                ooverflow <= 1'b1;
                            end else if (min_ones == 4'd9) begin
                                min_ones <= '0;
                                min_tens <= min_tens + 3'd1;
                            end else begin
                                min_ones <= min_ones + 4'd1;
                            end
                        end else begin
                            sec_tens <= sec_tens + 3'd1;
                        end
                    end else begin
                        sec_ones <= sec_ones + 4'd1;
                    end
                end else begin
                    tenths <= tenths + 4'd1;
                end
            end

            if (clr_ev && state == PAUSE) begin
                state     <= IDLE;
                orunning  <= 1'b0;
                ofrozen   <= 1'b0;
                ooverflow <= 1'b0;
                tenths    <= '0;
                sec_ones  <= '0;
                sec_tens  <= '0;
                min_ones  <= '0;
                min_tens  <= '0;
            end else begin
                if (ss_ev) begin
                    if (state == RUN) begin
                        state    <= PAUSE;
                        orunning <= 1'b0;
                    end else begin
                        state    <= RUN;
                        orunning <= 1'b1;
                    end
                end
                if (lap_ev && state != IDLE) begin
                    if (ofrozen) begin
                        ofrozen <= 1'b0;
                    end else begin
                        ofrozen       <= 1'b1;
                        snap_tenths   <= tenths;
                        snap_sec_ones <= sec_ones;
                        snap_sec_tens <= sec_tens;
                        snap_min_ones <= min_ones;
                        snap_min_tens <= min_tens;
                    end
                end
            end
        end
    end

    always_comb begin
        otenths   = ofrozen ? snap_tenths   : tenths;
        osec_ones = ofrozen ? snap_sec_ones : sec_ones;
        osec_tens = ofrozen ? snap_sec_tens : sec_tens;
        omin_ones = ofrozen ? snap_min_ones : min_ones;
        omin_tens = ofrozen ? snap_min_tens : min_tens;
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: hand-computed display values checked after each step.
module tb_stopwatch_core;

    logic       iclk = 1'b0;
    logic       irst_n = 1'b0;
    logic       itick_10hz = 1'b1;
    logic       istart_stop = 1'b0;
    logic       iclear = 1'b0;
    logic       ilap = 1'b0;
    logic [3:0] otenths, osec_ones, omin_ones;
    logic [2:0] osec_tens, omin_tens;
    logic       orunning, ofrozen, ooverflow;

    int n_cmp = 0;
    int n_bad = 0;

    stopwatch_core #(.MIN_LIMIT(60)) dut (
        .iclk        (iclk),
        .irst_n      (irst_n),
        .itick_10hz  (itick_10hz),
        .istart_stop (istart_stop),
        .iclear      (iclear),
        .ilap        (ilap),
        .otenths     (otenths),
        .osec_ones   (osec_ones),
        .osec_tens   (osec_tens),
        .omin_ones   (omin_ones),
        .omin_tens   (omin_tens),
        .orunning    (orunning),
        .ofrozen     (ofrozen),
        .ooverflow   (ooverflow)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] tm(input int mt, input int mo, input int st, input int so, input int t);
        return {14'd0, 3'(mt), 4'(mo), 3'(st), 4'(so), 4'(t)};
    endfunction

    function automatic logic [31:0] disp();
        return {14'd0, omin_tens, omin_ones, osec_tens, osec_ones, otenths};
    endfunction

    // One two-cycle step: inputs high for one edge, then low for one edge.
    task automatic step(input logic t, input logic s, input logic c, input logic l);
        @(posedge iclk); #1;
        itick_10hz = t; istart_stop = s; iclear = c; ilap = l;
        @(posedge iclk); #1;
        itick_10hz = 1'b0; istart_stop = 1'b0; iclear = 1'b0; ilap = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset with tick input held high: no spurious count after release.
        #23 irst_n = 1'b1;
        @(posedge iclk); #1;
        chk("rst_disp", disp(), tm(0,0,0,0,0));
        chk("rst_run", 32'(orunning), 32'd0);
        chk("rst_frz", 32'(ofrozen), 32'd0);
        chk("rst_ovf", 32'(ooverflow), 32'd0);
        itick_10hz = 1'b0;

        ticks(5);
        chk("idle_ticks", disp(), tm(0,0,0,0,0));
        chk("idle_run", 32'(orunning), 32'd0);
        step(0,0,0,1);
        chk("idle_lap", 32'(ofrozen), 32'd0);

        step(0,1,0,0);
        chk("start_run", 32'(orunning), 32'd1);
        ticks(25);
        chk("t25", disp(), tm(0,0,0,2,5));
        step(0,1,0,0);
        chk("stop_run", 32'(orunning), 32'd0);
        ticks(3);
        chk("pause_hold", disp(), tm(0,0,0,2,5));
        step(0,1,0,0);
        ticks(1);
        chk("resume", disp(), tm(0,0,0,2,6));

        // Tick with stop counts; tick with start from PAUSE does not.
        step(1,1,0,0);
        chk("tick_stop", disp(), tm(0,0,0,2,7));
        chk("tick_stop_run", 32'(orunning), 32'd0);
        step(1,1,0,0);
        chk("tick_start", disp(), tm(0,0,0,2,7));
        chk("tick_start_run", 32'(orunning), 32'd1);

        step(0,1,0,0);
        step(0,0,1,0);
        chk("clr_pause", disp(), tm(0,0,0,0,0));
        chk("clr_pause_run", 32'(orunning), 32'd0);

        // Lap freeze and release.
        step(0,1,0,0);
        ticks(13);
        step(0,0,0,1);
        chk("lap_frz", 32'(ofrozen), 32'd1);
        chk("lap_disp", disp(), tm(0,0,0,1,3));
        ticks(7);
        chk("lap_hold", disp(), tm(0,0,0,1,3));
        step(0,0,0,1);
        chk("lap_rel", 32'(ofrozen), 32'd0);
        chk("lap_live", disp(), tm(0,0,0,2,0));

        step(0,0,1,0);
        chk("clr_run", disp(), tm(0,0,0,2,0));
        chk("clr_run_run", 32'(orunning), 32'd1);
        step(0,1,0,0);
        step(0,1,1,0);
        chk("clr_start", disp(), tm(0,0,0,0,0));
        chk("clr_start_run", 32'(orunning), 32'd0);

        // Clear and lap together in PAUSE while frozen.
        step(0,1,0,0);
        ticks(3);
        step(0,0,0,1);
        step(0,1,0,0);
        chk("frz_pause", disp(), tm(0,0,0,0,3));
        step(0,0,1,1);
        chk("clr_lap_frz", 32'(ofrozen), 32'd0);
        chk("clr_lap_disp", disp(), tm(0,0,0,0,0));

        // Asynchronous reset mid-run.
        step(0,1,0,0);
        ticks(47);
        chk("t47", disp(), tm(0,0,0,4,7));
        #3 irst_n = 1'b0;
        #1;
        chk("arst_disp", disp(), tm(0,0,0,0,0));
        chk("arst_run", 32'(orunning), 32'd0);
        #10 irst_n = 1'b1;
        ticks(3);
        chk("post_rst", disp(), tm(0,0,0,0,0));
        @(posedge iclk); #1 istart_stop = 1'b1;
        repeat (20) @(posedge iclk);
        #1 istart_stop = 1'b0;
        chk("hold_run", 32'(orunning), 32'd1);
        ticks(2);
        chk("hold_cnt", disp(), tm(0,0,0,0,2));

        // Full-range run to the wrap point.
        step(0,1,0,0);
        step(0,0,1,0);
        step(0,1,0,0);
        ticks(35999);
        chk("t35999", disp(), tm(5,9,5,9,9));
        chk("pre_wrap_ovf", 32'(ooverflow), 32'd0);
        ticks(1);
        chk("wrap_disp", disp(), tm(0,0,0,0,0));
        chk("wrap_ovf", 32'(ooverflow), 32'd1);
        ticks(1);
        chk("ovf_sticky", 32'(ooverflow), 32'd1);
        chk("post_wrap", disp(), tm(0,0,0,0,1));
        step(0,1,0,0);
        step(0,0,1,0);
        chk("clr_ovf", 32'(ooverflow), 32'd0);
        chk("clr_ovf_disp", disp(), tm(0,0,0,0,0));
        step(0,1,0,0);
        chk("idle_after_clr", 32'(orunning), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
